vmem_fill_engine: RTL and testbench

- Memory-mapped rectangle-fill engine sitting directly upstream of the vmem write port.
- The CPU programs origin, size and 3-bit colour over dbus, then starts the engine. The engine emits one vmem write per cycle, addressed {y,x}, the same address format the ST7789 scan-out reads at LCD_ROTATE==0.
- CPU vmem writes pass through the block and always win arbitration.
- Clears or fills large screen areas without a per-pixel CPU store loop.

---
 rtl/vmem_fill_engine.sv | 169 ++++++++++++++++
 tb/tb_vmem_fill_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_fill_engine.sv
// vmem_fill_engine: memory-mapped rectangle fill sitting in front of the vmem
// write port. The CPU programs the origin, size and colour, then starts a fill.
// The engine streams one {y,x}-addressed write per cycle. CPU writes always
// take the port, and the engine simply holds its position while they do.
module vmem_fill_engine #(
    parameter int SCR_W = 240,
    parameter int SCR_H = 240
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_we_i,
    input  logic [3:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    input  logic        cpu_vmem_we_i,
    input  logic [15:0] cpu_vmem_addr_i,
    input  logic [2:0]  cpu_vmem_wdata_i,
    output logic        vmem_we_o,
    output logic [15:0] vmem_addr_o,
    output logic [2:0]  vmem_wdata_o,
    output logic        busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [8:0] SCR_W9 = 9'(SCR_W);
    localparam logic [8:0] SCR_H9 = 9'(SCR_H);

    // Clipped extent along one axis. The 9-bit width keeps org+len from wrapping.
    function automatic logic [8:0] clip_extent(input logic [7:0] org,
                                               input logic [7:0] len,
                                               input logic [8:0] lim);
        logic [8:0] room;
        room = lim - {1'b0, org};
        if ({1'b0, org} >= lim)
            return 9'd0;
        else if ({1'b0, len} < room)
            return {1'b0, len};
        else
            return room;
    endfunction

    logic [0:0] state;
    logic [7:0] x0, y0, w, h;
    logic [2:0] color;
    logic       done;
    logic [7:0] cur_x, cur_y, col_cnt, row_cnt, ew_m1;
    logic [2:0] color_lat;

    logic [8:0] ew_c, eh_c;
    logic       ctrl_hit, start_c, abort_c, eng_fire, last_c, run;
    logic       unused_wdata;

    assign ew_c     = clip_extent(x0, w, SCR_W9);
    assign eh_c     = clip_extent(y0, h, SCR_H9);
    assign run      = (state == ST_RUN);
    assign ctrl_hit = cfg_we_i && (cfg_addr_i == 4'h0);
    assign start_c  = ctrl_hit && cfg_wdata_i[0];
    assign abort_c  = ctrl_hit && cfg_wdata_i[1];
    assign eng_fire = run && !cpu_vmem_we_i;
    assign last_c   = eng_fire && (col_cnt == 8'd0) && (row_cnt == 8'd0);
    assign unused_wdata = &{1'b0, cfg_wdata_i[31:16]};

    // Config registers; frozen while a fill is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            color <= '0;
        end else if (cfg_we_i && !run) begin
            case (cfg_addr_i)
                4'h4: begin
                    x0 <= cfg_wdata_i[7:0];
                    y0 <= cfg_wdata_i[15:8];
                end
                4'h8: begin
                    w <= cfg_wdata_i[7:0];
                    h <= cfg_wdata_i[15:8];
                end
                4'hC: color <= cfg_wdata_i[2:0];
                default: ;
            endcase
        end
    end

    // Fill FSM: start/abort handling, raster walk and completion flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            ew_m1     <= '0;
            color_lat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        if (ew_c == 9'd0 || eh_c == 9'd0) begin
                            done <= 1'b1;
                        end else begin
                            done      <= 1'b0;
                            cur_x     <= x0;
                            cur_y     <= y0;
                            col_cnt   <= 8'(ew_c - 9'd1);
                            ew_m1     <= 8'(ew_c - 9'd1);
                            row_cnt   <= 8'(eh_c - 9'd1);
                            color_lat <= color;
                            state     <= ST_RUN;
                        end
                    end
                end
                default: begin
                    if (abort_c) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end else if (last_c) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else if (eng_fire) begin
                        if (col_cnt == 8'd0) begin
                            cur_x   <= x0;
                            cur_y   <= cur_y + 8'd1;
                            col_cnt <= ew_m1;
                            row_cnt <= row_cnt - 8'd1;
                        end else begin
                            cur_x   <= cur_x + 8'd1;
                            col_cnt <= col_cnt - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Registered readback, refreshed every cycle from the presented offset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rdata_o <= '0;
        end else begin
            case (cfg_addr_i)
                4'h0:    cfg_rdata_o <= {30'd0, done, run};
                4'h4:    cfg_rdata_o <= {16'd0, y0, x0};
                4'h8:    cfg_rdata_o <= {16'd0, h, w};
                4'hC:    cfg_rdata_o <= {29'd0, color};
                default: cfg_rdata_o <= '0;
            endcase
        end
    end

    // Write port mux: the engine drives it only when running and the CPU is quiet.
    always_comb begin
        vmem_we_o    = cpu_vmem_we_i | eng_fire;
        vmem_addr_o  = cpu_vmem_addr_i;
        vmem_wdata_o = cpu_vmem_wdata_i;
        if (eng_fire) begin
            vmem_addr_o  = {cur_y, cur_x};
            vmem_wdata_o = color_lat;
        end
    end

    assign busy_o = run;

endmodule

// File: tb/tb_vmem_fill_engine.sv
// Bench for vmem_fill_engine: table of fill rectangles checked against a
// scoreboard of expected vmem writes, plus hand sequences for stall, abort,
// async reset and config lock.
module tb_vmem_fill_engine;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [2:0]  cpu_wdata;
    logic        vmem_we;
    logic [15:0] vmem_addr;
    logic [2:0]  vmem_wdata;
    logic        busy;

    vmem_fill_engine #(.SCR_W(240), .SCR_H(240)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cfg_we_i        (cfg_we),
        .cfg_addr_i      (cfg_addr),
        .cfg_wdata_i     (cfg_wdata),
        .cfg_rdata_o     (cfg_rdata),
        .cpu_vmem_we_i   (cpu_we),
        .cpu_vmem_addr_i (cpu_addr),
        .cpu_vmem_wdata_i(cpu_wdata),
        .vmem_we_o       (vmem_we),
        .vmem_addr_o     (vmem_addr),
        .vmem_wdata_o    (vmem_wdata),
        .busy_o          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int x0;
        int y0;
        int w;
        int h;
        int c;
        int n;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] exp_q[$];
    logic        sb_en = 1'b0;
    int          wr_cnt = 0;
    int          busy_cnt = 0;
    logic [15:0] last_addr = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge away from input changes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (vmem_we) begin
                wr_cnt++;
                last_addr = vmem_addr;
                if (sb_en) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_extra: got write 0x%0h/%0d expected none", vmem_addr, vmem_wdata);
                    end else begin
                        logic [18:0] e;
                        e = exp_q.pop_front();
                        if ({vmem_addr, vmem_wdata} !== e) begin
                            n_errors++;
                            $display("FAIL sb_write: got 0x%0h/%0d expected 0x%0h/%0d",
                                     vmem_addr, vmem_wdata, e[18:3], e[2:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        cfg_addr = a;
        @(posedge clk); #1;
        d = cfg_rdata;
    endtask

    task automatic program_rect(input int x0, input int y0, input int w, input int h, input int c);
        cfg_write(4'h4, 32'((y0 << 8) | x0));
        cfg_write(4'h8, 32'((h << 8) | w));
        cfg_write(4'hC, 32'(c));
    endtask

    // Reference raster: clip against a 240x240 screen and queue every pixel.
    task automatic push_model(input int x0, input int y0, input int w, input int h, input int c);
        for (int yy = y0; yy < y0 + h && yy < 240; yy++)
            for (int xx = x0; xx < x0 + w && xx < 240; xx++)
                exp_q.push_back({8'(yy), 8'(xx), 3'(c)});
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 70000; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (busy) check({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_counts();
        wr_cnt = 0;
        busy_cnt = 0;
    endtask

    vec_t        tbl[7];
    logic [31:0] rd;
    int          snap;
    logic [15:0] exp_last;

    initial begin
        tbl[0] = '{16, 20, 2, 3, 5, 6};
        tbl[1] = '{238, 239, 5, 4, 2, 2};
        tbl[2] = '{240, 0, 5, 5, 7, 0};
        tbl[3] = '{0, 239, 1, 5, 1, 1};
        tbl[4] = '{239, 3, 3, 2, 4, 2};
        tbl[5] = '{10, 10, 0, 4, 3, 0};
        tbl[6] = '{0, 0, 240, 240, 6, 57600};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 4'h0; cfg_wdata = '0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #1;
        check("rst_rdata", cfg_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(vmem_we), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven fills checked through the scoreboard.
        sb_en = 1'b1;
        for (int v = 0; v < 7; v++) begin
            program_rect(tbl[v].x0, tbl[v].y0, tbl[v].w, tbl[v].h, tbl[v].c);
            push_model(tbl[v].x0, tbl[v].y0, tbl[v].w, tbl[v].h, tbl[v].c);
            exp_last = exp_q.size() > 0 ? exp_q[exp_q.size() - 1][18:3] : 16'h0;
            clear_counts();
            cfg_write(4'h0, 32'h1);
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_writes", v), 32'(wr_cnt), 32'(tbl[v].n));
            check($sformatf("vec%0d_busy", v), 32'(busy_cnt), 32'(tbl[v].n));
            check($sformatf("vec%0d_left", v), 32'(exp_q.size()), 32'd0);
            if (tbl[v].n > 0)
                check($sformatf("vec%0d_last", v), 32'(last_addr), 32'(exp_last));
            cfg_read(4'h0, rd);
            check($sformatf("vec%0d_ctrl", v), rd, 32'h2);
            exp_q.delete();
        end

        // CPU stall: two pass-through writes interleaved into a 4x1 fill.
        program_rect(0, 0, 4, 1, 6);
        exp_q.push_back({16'h0000, 3'd6});
        exp_q.push_back({16'h1234, 3'd3});
        exp_q.push_back({16'h1234, 3'd3});
        exp_q.push_back({16'h0001, 3'd6});
        exp_q.push_back({16'h0002, 3'd6});
        exp_q.push_back({16'h0003, 3'd6});
        clear_counts();
        cfg_write(4'h0, 32'h1);
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 3'd3;
        repeat (2) @(posedge clk);
        #1 cpu_we = 1'b0;
        wait_idle("stall");
        check("stall_writes", 32'(wr_cnt), 32'd6);
        check("stall_busy", 32'(busy_cnt), 32'd6);
        check("stall_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Config lock and start+abort together from IDLE.
        program_rect(1, 2, 3, 2, 4);
        push_model(1, 2, 3, 2, 4);
        clear_counts();
        cfg_write(4'h0, 32'h3);
        check("both_busy", 32'(busy), 32'd1);
        cfg_write(4'h8, 32'h0101);
        cfg_write(4'hC, 32'h7);
        wait_idle("lock");
        check("lock_writes", 32'(wr_cnt), 32'd6);
        check("lock_left", 32'(exp_q.size()), 32'd0);
        cfg_read(4'h8, rd);
        check("lock_size", rd, 32'h0203);
        cfg_read(4'hC, rd);
        check("lock_color", rd, 32'h4);
        exp_q.delete();

        // Abort a full-screen fill partway.
        sb_en = 1'b0;
        program_rect(0, 0, 240, 240, 1);
        clear_counts();
        cfg_write(4'h0, 32'h1);
        repeat (50) @(posedge clk);
        cfg_write(4'h0, 32'h3);
        check("abort_busy", 32'(busy), 32'd0);
        snap = wr_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("abort_stop", 32'(wr_cnt), 32'(snap));
        check("abort_some", 32'(snap > 0 && snap < 100), 32'd1);
        cfg_read(4'h0, rd);
        check("abort_ctrl", rd, 32'h0);
        sb_en = 1'b1;
        program_rect(5, 5, 1, 1, 2);
        push_model(5, 5, 1, 1, 2);
        cfg_write(4'h0, 32'h1);
        check("restart_busy", 32'(busy), 32'd1);
        wait_idle("restart");
        check("restart_left", 32'(exp_q.size()), 32'd0);
        cfg_read(4'h0, rd);
        check("restart_ctrl", rd, 32'h2);
        exp_q.delete();

        // Asynchronous reset in the middle of a fill.
        sb_en = 1'b0;
        program_rect(3, 4, 10, 10, 5);
        cfg_write(4'h0, 32'h1);
        cfg_addr = 4'h4;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_rdata", cfg_rdata, 32'h0403);
        #1 rst_n = 1'b0;
        #1;
        check("arst_we", 32'(vmem_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rdata", cfg_rdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cfg_read(4'h4, rd);
        check("arst_org", rd, 32'h0);
        cfg_read(4'h8, rd);
        check("arst_size", rd, 32'h0);
        cfg_read(4'hC, rd);
        check("arst_color", rd, 32'h0);
        cfg_read(4'h0, rd);
        check("arst_ctrl", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
